park_gate_ctrl: RTL

PARK_GATE_CTRL -- requirements
Module: park_gate_ctrl

---
 rtl/park_gate_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/park_gate_ctrl.sv
// park_gate_ctrl: parking-lot barrier controller.
//
// Serves entry/exit requests from one-cycle key pulses. Each accepted request raises its
// barrier for exactly OPEN_CYCLES clocks and adjusts the occupancy count. A request that
// arrives while a barrier is up is held in a one-deep pending slot and evaluated in the
// single idle cycle after the barrier drops.
//
// Ports:
//   CLOCK_50         in   system clock, rising edge
//   resetn           in   asynchronous active-low reset
//   enter_pressed    in   one-cycle entry request pulse
//   esc_pressed      in   one-cycle exit request pulse
//   entry_gate_open  out  entry barrier raised
//   exit_gate_open   out  exit barrier raised
//   occupancy        out  number of parked cars [CNT_W-1:0]
//   lot_full         out  occupancy == CAPACITY
//   lot_empty        out  occupancy == 0
//   reject           out  one-cycle pulse when a request is refused or dropped

module park_gate_ctrl #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned OPEN_CYCLES = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             enter_pressed,
  input  logic             esc_pressed,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             reject
);

  // Timer counts OPEN_CYCLES-1 down to 0, so it only needs to hold OPEN_CYCLES-1.
  localparam int unsigned      TimerW    = $clog2(OPEN_CYCLES);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CapVal    = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    StIdle,
    StEntryOpen,
    StExitOpen
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_exit_q, pend_exit_d;  // pending direction: 1 = exit, 0 = entry
  logic               reject_q, reject_d;

  logic               full, empty;
  logic               serve_req;   // a request is evaluated against full/empty this cycle
  logic               serve_exit;  // direction of the request being evaluated
  logic               hold_rules;  // incoming pulses go to the pending slot, not served
  logic               slot_free;   // pending slot can accept a new request this cycle

  assign full  = (occ_q == CapVal);
  assign empty = (occ_q == '0);

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      occ_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_exit_q  <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      occ_q        <= occ_d;
      pend_valid_q <= pend_valid_d;
      pend_exit_q  <= pend_exit_d;
      reject_q     <= reject_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    occ_d        = occ_q;
    pend_valid_d = pend_valid_q;
    pend_exit_d  = pend_exit_q;
    reject_d     = 1'b0;
    serve_req    = 1'b0;
    serve_exit   = 1'b0;
    hold_rules   = 1'b0;
    slot_free    = !pend_valid_q;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          // Serve the held request; the slot is consumed this cycle, so fresh pulses
          // may refill it under the same rules as during an open barrier.
          serve_req    = 1'b1;
          serve_exit   = pend_exit_q;
          pend_valid_d = 1'b0;
          hold_rules   = 1'b1;
          slot_free    = 1'b1;
        end else if (esc_pressed) begin
          serve_req  = 1'b1;
          serve_exit = 1'b1;
          // Simultaneous pulses: exit wins, entry waits in the slot.
          if (enter_pressed) begin
            pend_valid_d = 1'b1;
            pend_exit_d  = 1'b0;
          end
        end else if (enter_pressed) begin
          serve_req  = 1'b1;
          serve_exit = 1'b0;
        end
      end
      StEntryOpen, StExitOpen: begin
        hold_rules = 1'b1;
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Full/empty checks keep occupancy from ever wrapping.
    if (serve_req) begin
      if (serve_exit) begin
        if (empty) begin
          reject_d = 1'b1;
        end else begin
          state_d = StExitOpen;
          timer_d = TimerLoad;
          occ_d   = occ_q - CNT_W'(1);
        end
      end else begin
        if (full) begin
          reject_d = 1'b1;
        end else begin
          state_d = StEntryOpen;
          timer_d = TimerLoad;
          occ_d   = occ_q + CNT_W'(1);
        end
      end
    end

    if (hold_rules) begin
      if (enter_pressed && esc_pressed) begin
        // Exit is kept if there is room; entry is always dropped.
        reject_d = 1'b1;
        if (slot_free) begin
          pend_valid_d = 1'b1;
          pend_exit_d  = 1'b1;
        end
      end else if (enter_pressed || esc_pressed) begin
        if (slot_free) begin
          pend_valid_d = 1'b1;
          pend_exit_d  = esc_pressed;
        end else begin
          reject_d = 1'b1;
        end
      end
    end
  end

  // Outputs: decodes of registered state only
  always_comb begin
    entry_gate_open = (state_q == StEntryOpen);
    exit_gate_open  = (state_q == StExitOpen);
    occupancy       = occ_q;
    lot_full        = full;
    lot_empty       = empty;
    reject          = reject_q;
  end

endmodule
